// File: rtl/dmem_access_ctrl_pkg.sv
// rtl/dmem_access_ctrl_pkg.sv - shared state encoding and widths for the memory-stage sequencer
package dmem_access_ctrl_pkg;

    localparam int unsigned DW_DEFAULT = 16;
    localparam int unsigned CNT_W      = 16;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_REQ  = 3'd1,
        ST_WAIT = 3'd2,
        ST_DONE = 3'd3,
        ST_HALT = 3'd4
    } state_t;

    function automatic logic in_access(input state_t s);
        return (s == ST_REQ) || (s == ST_WAIT);
    endfunction

endpackage

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - saturating up-counter with synchronous clear and enable
module sat_counter
    import dmem_access_ctrl_pkg::*;
(
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             clr_i,
    input  logic             en_i,
    output logic [CNT_W-1:0] cnt_o
);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Clear wins over enable so a new access always starts from zero.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i && (cnt_q != '1)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/dmem_access_ctrl.sv
// rtl/dmem_access_ctrl.sv - MEM-stage sequencer between EX/MEM and the multi-cycle data cache
module dmem_access_ctrl
    import dmem_access_ctrl_pkg::*;
#(
    parameter int unsigned DW        = DW_DEFAULT,
    parameter int unsigned TO_CYCLES = 255
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             mem_en_ex_mem,
    input  logic             mem_wr_ex_mem,
    input  logic [DW-1:0]    addr_ex_mem,
    input  logic [DW-1:0]    wdata_ex_mem,
    input  logic             halt_ex_mem,
    input  logic             dc_rdy,
    input  logic             dc_done,
    input  logic             dc_err,
    input  logic [DW-1:0]    dc_rdata,
    output logic             dc_req,
    output logic             dc_wr,
    output logic [DW-1:0]    dc_addr,
    output logic [DW-1:0]    dc_wdata,
    output logic [DW-1:0]    rdata_mem,
    output logic             stall_pipe,
    output logic             bubble_mem_wb,
    output logic             err,
    output logic             halted,
    output logic [CNT_W-1:0] stall_cnt
);

    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TO_CYCLES - 1);

    state_t           state_q, state_d;
    logic             err_q, err_d;
    logic             halted_q, halted_d;
    logic [DW-1:0]    rdata_q, rdata_d;
    logic [CNT_W-1:0] to_cnt;
    logic             req_c, stall_c;
    logic             issue, in_acc, to_hit;

    assign in_acc = in_access(state_q);
    assign issue  = (state_q == ST_IDLE) && mem_en_ex_mem && !halt_ex_mem;
    // The counter holds the number of REQ/WAIT cycles already finished, so
    // hitting TO_LAST means this is the TO_CYCLES-th such cycle.
    assign to_hit = in_acc && (to_cnt == TO_LAST);

    always_comb begin
        state_d  = state_q;
        err_d    = err_q;
        halted_d = halted_q;
        rdata_d  = rdata_q;
        req_c    = 1'b0;
        stall_c  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (halt_ex_mem) begin
                    stall_c  = 1'b1;
                    halted_d = 1'b1;
                    state_d  = ST_HALT;
                end else if (mem_en_ex_mem) begin
                    req_c   = 1'b1;
                    stall_c = 1'b1;
                    state_d = dc_rdy ? ST_WAIT : ST_REQ;
                end
            end
            ST_REQ: begin
                req_c   = 1'b1;
                stall_c = 1'b1;
                if (to_hit) begin
                    err_d    = 1'b1;
                    halted_d = 1'b1;
                    state_d  = ST_HALT;
                end else if (dc_rdy) begin
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                stall_c = 1'b1;
                if (to_hit || (dc_done && dc_err)) begin
                    err_d    = 1'b1;
                    halted_d = 1'b1;
                    state_d  = ST_HALT;
                end else if (dc_done) begin
                    if (!mem_wr_ex_mem) begin
                        rdata_d = dc_rdata;
                    end
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            ST_HALT: begin
                stall_c = 1'b1;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= ST_IDLE;
            err_q    <= 1'b0;
            halted_q <= 1'b0;
            rdata_q  <= '0;
        end else begin
            state_q  <= state_d;
            err_q    <= err_d;
            halted_q <= halted_d;
            rdata_q  <= rdata_d;
        end
    end

    sat_counter u_to_cnt (
        .clk_i  (clk),
        .rst_ni (rst),
        .clr_i  (issue),
        .en_i   (in_acc),
        .cnt_o  (to_cnt)
    );

    sat_counter u_stall_cnt (
        .clk_i  (clk),
        .rst_ni (rst),
        .clr_i  (1'b0),
        .en_i   (in_acc && stall_c),
        .cnt_o  (stall_cnt)
    );

    // Gating with rst drops the request the instant reset asserts, even
    // though IDLE with mem_en would otherwise raise it combinationally.
    assign dc_req        = rst && req_c;
    assign stall_pipe    = rst && stall_c;
    assign bubble_mem_wb = stall_pipe;
    assign dc_wr         = dc_req && mem_wr_ex_mem;
    assign dc_addr       = dc_req ? addr_ex_mem : '0;
    assign dc_wdata      = dc_req ? wdata_ex_mem : '0;
    assign rdata_mem     = rdata_q;
    assign err           = err_q;
    assign halted        = halted_q;

endmodule

// File: doc/dmem_access_ctrl.md
Name: dmem_access_ctrl

Overview:
- Memory-stage sequencer for the 5-stage pipeline; sits between the EX/MEM pipeline register outputs and the multi-cycle data cache.
- Issues one cache request per memory instruction in EX/MEM and freezes upstream stages until the access completes.
- Captures read data for MEM/WB, turns halts into a clean stop, and flags cache errors and timeouts.

Parameters:
- DW, 16, data and address width
- TO_CYCLES, 255, max cycles REQ+WAIT before timeout error (1..65535)

Ports:
- clk  in  1  single clock, rising edge
- rst  in  1  asynchronous, active-low reset
- mem_en_ex_mem  in  1  EX/MEM instruction accesses memory
- mem_wr_ex_mem  in  1  access is a store (valid with mem_en_ex_mem)
- addr_ex_mem  in  DW  access address (ALU result)
- wdata_ex_mem  in  DW  store data
- halt_ex_mem  in  1  EX/MEM holds HALT
- dc_rdy  in  1  cache accepts a request this cycle
- dc_done  in  1  one-cycle pulse, access complete
- dc_err  in  1  error qualifier, sampled with dc_done
- dc_rdata  in  DW  load data, valid with dc_done
- dc_req  out  1  request valid
- dc_wr  out  1  request is a write
- dc_addr  out  DW  request address
- dc_wdata  out  DW  request write data
- rdata_mem  out  DW  captured load data for MEM/WB
- stall_pipe  out  1  freeze PC, IF/ID, ID/EX, EX/MEM
- bubble_mem_wb  out  1  load NOP into MEM/WB
- err  out  1  sticky error flag
- halted  out  1  sticky halt flag
- stall_cnt  out  16  saturating count of memory stall cycles

Behaviour:
- States: IDLE, REQ, WAIT, DONE, HALT.
- Reset: while rst=0, asynchronously force state=IDLE and all registered outputs to 0: rdata_mem, err, halted, stall_cnt, and the timeout counter. dc_req drops in the same instant. A reset mid-access abandons the access without completing it.
- IDLE, halt_ex_mem=1: go to HALT. mem_en_ex_mem is ignored (halt has priority).
- IDLE, mem_en_ex_mem=1: stall_pipe=1 and dc_req=1 combinationally. Go to WAIT if dc_rdy=1, else REQ.
- IDLE, otherwise: stall_pipe=0 and dc_req=0.
- REQ: dc_req=1 and stall_pipe=1. Go to WAIT on dc_rdy=1.
- WAIT: dc_req=0 and stall_pipe=1.
  - dc_done=1 and dc_err=0: register dc_rdata into rdata_mem (load only; unchanged on store) and go to DONE.
  - dc_done=1 and dc_err=1: set err and go to HALT.
  - dc_done is ignored in every state except WAIT.
- DONE: one cycle with stall_pipe=0, so EX/MEM and MEM/WB advance. The controller cannot reissue for the same instruction. Always return to IDLE.
- dc_wr, dc_addr, dc_wdata: equal mem_wr_ex_mem, addr_ex_mem, wdata_ex_mem whenever dc_req=1 (EX/MEM is frozen, so they stay stable). When dc_req=0, drive them to 0.
- Best-case latency: 3 cycles per memory instruction (IDLE -> WAIT -> DONE), with dc_rdy in the issue cycle and dc_done on the first WAIT cycle.
- Timeout counter:
  - Clears on IDLE -> REQ/WAIT and increments each cycle in REQ or WAIT.
  - When it reaches TO_CYCLES: set err and go to HALT (takes priority over a same-cycle dc_done).
- HALT: terminal until reset. halted=1, stall_pipe=1, dc_req=0.
- bubble_mem_wb = stall_pipe in every state, so a stalled instruction never writes back twice.
- stall_cnt: +1 on each cycle where stall_pipe=1 and state is REQ or WAIT (the IDLE issue cycle is not counted). Saturates at 0xFFFF.

Decomposition:
- Shared package: state encoding constants (IDLE=0, REQ=1, WAIT=2, DONE=3, HALT=4, 3 bits), DW default, counter width 16.
- One sub-module, sat_counter (16-bit, sync clear, enable, saturate, async active-low reset). Instantiate it twice: timeout counter and stall_cnt.

Test Plan:
- Load, dc_rdy=1, dc_done one cycle later with dc_rdata=0xBEEF, addr_ex_mem=0x0040:
  - dc_req=1 for 1 cycle, dc_addr=0x0040, dc_wr=0.
  - stall_pipe high 2 cycles then low 1 cycle (DONE).
  - rdata_mem=0xBEEF; stall_cnt=1.
- Store, wdata=0x1234, dc_rdy low 3 cycles, dc_done after 4 WAIT cycles:
  - dc_req high 4 cycles with dc_wr=1, dc_wdata=0x1234.
  - rdata_mem unchanged; stall_cnt=7; no reissue in DONE.
- Back-to-back loads to 0x0002 and 0x0004:
  - Two separate dc_req pulses separated by DONE and IDLE.
  - Exactly two DONE cycles.
- TO_CYCLES=8, dc_done never asserted:
  - err=1 and state HALT after 8 REQ/WAIT cycles.
  - halted=1, stall_pipe stuck at 1.
- dc_done with dc_err=1:
  - err=1, halted=1 next cycle.
  - rdata_mem not updated.
- halt_ex_mem=1 together with mem_en_ex_mem=1:
  - No dc_req; halted=1 next cycle.
- rst pulled low while in WAIT:
  - dc_req/stall_pipe drop immediately, all outputs 0.
  - After release, the next mem_en starts cleanly from IDLE.
